// File: rtl/mux_sched_pkg.sv
// -----------------------------------------------------------------------------
// mux_sched_pkg
// Shared types and constants for the round-robin mux scheduler.
//   state_e        : scheduler FSM states (IDLE, GRANT)
//   N              : requester count (fixed at 8 in this revision)
//   SEL_W          : width of the mux select / round-robin pointer
//   sel_to_onehot  : converts a select index into a one-hot grant vector
// -----------------------------------------------------------------------------
package mux_sched_pkg;

    localparam int N     = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [N-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [N-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_rr_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority finder. Searches req starting at ptr+1 and
// wrapping around so that ptr itself is examined last.
// Ports:
//   req   [N-1:0]     in   request vector
//   ptr   [SEL_W-1:0] in   index granted last
//   win   [SEL_W-1:0] out  index of the first set request in search order
//   found             out  high when any request bit is set
// -----------------------------------------------------------------------------
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             found
);

    logic [SEL_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest set
    // request is the last one written and therefore wins. The offset N
    // wraps to ptr itself in SEL_W-bit arithmetic.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_rr_sched
// Round-robin scheduler for an 8:1 mux. A requester holds the grant until it
// releases, drops its request or (optionally) hits the hold timeout; the next
// winner is granted on the same edge so there is no idle bubble.
//
// Optional feature: define MUX_RR_SCHED_TIMEOUT_EN to limit a grant to
// HOLD_MAX consecutive cycles and pulse to_evt when a grant ends that way.
// Without the macro there is no hold counter and to_evt is tied low.
//
// Parameters:
//   HOLD_MAX  max consecutive grant cycles with timeout enabled (1..15)
//   N         requester count, must be 8
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req [7:0] in   level-sensitive requests
//   rel       in   current grantee releases (only looked at while granted)
//   gnt [7:0] out  one-hot grant, zero when idle
//   s   [2:0] out  mux select, index of the granted requester
//   gnt_vld   out  high when gnt is non-zero
//   to_evt    out  one-cycle pulse when a grant ends by timeout
// -----------------------------------------------------------------------------
module mux_rr_sched
    import mux_sched_pkg::*;
#(
    parameter int HOLD_MAX = 4,
    parameter int N        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             rel,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] s,
    output logic             gnt_vld,
    output logic             to_evt
);

    generate
        if (N != mux_sched_pkg::N) begin : g_bad_n
            $error("mux_rr_sched: N must be 8 in this revision");
        end
        if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold
            $error("mux_rr_sched: HOLD_MAX must be in 1..15");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [N-1:0]     gnt_q, gnt_d;
    logic [SEL_W-1:0] s_q, s_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    // arm_q blocks granting on the first edge after reset release, so the
    // earliest grant lands on the second rising edge.
    logic             arm_q;

    logic [SEL_W-1:0] win;
    logic             found;
    logic             tmo;
    logic             grant_end;
    logic             new_grant;
    logic             to_evt_d;

    rr_pick u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .win   (win),
        .found (found)
    );

`ifdef MUX_RR_SCHED_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       to_evt_q;

    assign tmo = (cnt_q == 4'(HOLD_MAX - 1));

    // Clears on a new grant, counts while granted, parks at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (new_grant) begin
            cnt_d = '0;
        end else if (state_q == GRANT && !tmo) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            to_evt_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_evt_q <= to_evt_d;
        end
    end

    assign to_evt = to_evt_q;
`else
    assign tmo    = 1'b0;
    assign to_evt = 1'b0;
`endif

    assign grant_end = (state_q == GRANT) && (rel || !req[s_q] || tmo);

    // Regrant search always starts after the last granted index, so a lone
    // releasing requester (rel/timeout with only req[s] set) wins again, while
    // a requester that dropped req[s] is naturally excluded.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        s_d       = s_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        to_evt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_q && found) begin
                    new_grant = 1'b1;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    to_evt_d = tmo && !rel;
                    if (found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                gnt_d     = '0;
                gnt_vld_d = 1'b0;
            end
        endcase

        if (new_grant) begin
            state_d   = GRANT;
            gnt_d     = sel_to_onehot(win);
            s_d       = win;
            gnt_vld_d = 1'b1;
            ptr_d     = win;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            s_q       <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= SEL_W'(N - 1);
            arm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            s_q       <= s_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
            arm_q     <= 1'b1;
        end
    end

    assign gnt     = gnt_q;
    assign s       = s_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
module tb_mux_rr_sched;

    localparam int HM = 4;
`ifdef MUX_RR_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       rel = 1'b0;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       gnt_vld;
    logic       to_evt;

    always #5 clk = ~clk;

    mux_rr_sched #(.HOLD_MAX(HM), .N(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .s       (s),
        .gnt_vld (gnt_vld),
        .to_evt  (to_evt)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] s;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: who owns the mux, who was served last, how long the
    // owner has held it, and what the select output shows.
    int m_owner;
    int m_last;
    int m_hold;
    int m_s;
    bit m_arm;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int rr_search(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_hold  = 0;
        m_s     = 0;
        m_arm   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_last  = w;
        m_s     = w;
        m_hold  = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rl, output exp_t e);
        bit to_ev;
        bit at_limit;
        int w;
        to_ev = 1'b0;
        if (!m_arm) begin
            m_arm = 1'b1;
        end else if (m_owner < 0) begin
            w = rr_search(r, m_last);
            if (w >= 0) model_grant(w);
        end else begin
            at_limit = TO_EN && (m_hold == HM - 1);
            if (rl || !r[m_owner] || at_limit) begin
                to_ev = at_limit && !rl;
                w = rr_search(r, m_last);
                if (w >= 0) model_grant(w);
                else m_owner = -1;
            end else if (m_hold < HM - 1) begin
                m_hold++;
            end
        end
        e.gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e.s   = 3'(m_s);
        e.vld = (m_owner >= 0);
        e.to  = to_ev;
    endtask

    // Stimulus: apply inputs mid-cycle and queue what the next edge must produce.
    task automatic drive(input logic [7:0] r, input logic rl);
        exp_t e;
        @(negedge clk);
        req = r;
        rel = rl;
        model_step(r, rl, e);
        sb_q.push_back(e);
    endtask

    // Asserts reset just after an edge, checks the asynchronous clear, and
    // releases mid-cycle so the following drive() lines up with the model.
    task automatic reset_pulse(input bit check_now);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = 8'($urandom);
        rel   = 1'($urandom);
        #1;
        if (check_now) begin
            chk("rst_async_gnt", int'(gnt), 0);
            chk("rst_async_s", int'(s), 0);
            chk("rst_async_vld", int'(gnt_vld), 0);
            chk("rst_async_to", int'(to_evt), 0);
        end
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs against queued expectations after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("gnt", int'(gnt), int'(e.gnt));
                chk("s", int'(s), int'(e.s));
                chk("gnt_vld", int'(gnt_vld), int'(e.vld));
                chk("to_evt", int'(to_evt), int'(e.to));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic       rl;

        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // single requester after reset: first edge arms, second grants index 0
        drive(8'h01, 1'b0);
        drive(8'h01, 1'b0);
        drive(8'h01, 1'b0);

        // all requesting, release every cycle: 0,1,...,7,0,1 back-to-back
        reset_pulse(1'b0);
        drive(8'hFF, 1'b0);
        drive(8'hFF, 1'b0);
        for (int i = 0; i < 10; i++) drive(8'hFF, 1'b1);

        // s=3, then 0x88 with rel -> 7, then 0x08 with rel -> 3
        reset_pulse(1'b0);
        drive(8'h08, 1'b0);
        drive(8'h08, 1'b0);
        drive(8'h88, 1'b1);
        drive(8'h08, 1'b1);
        drive(8'h08, 1'b0);

        // hold without release: timeout hands over to 2 only in timeout build
        reset_pulse(1'b0);
        drive(8'h05, 1'b0);
        for (int i = 0; i < 12; i++) drive(8'h05, 1'b0);

        // lone requester with rel keeps being regranted
        drive(8'h01, 1'b1);
        drive(8'h01, 1'b1);

        // reset in the middle of a grant at index 5
        reset_pulse(1'b0);
        drive(8'h20, 1'b0);
        drive(8'h20, 1'b0);
        drive(8'h20, 1'b0);
        reset_pulse(1'b1);
        drive(8'h20, 1'b0);
        drive(8'h20, 1'b0);

        // requester 6 drops with nobody else: idle, select holds 6
        reset_pulse(1'b0);
        drive(8'h40, 1'b0);
        drive(8'h40, 1'b0);
        drive(8'h00, 1'b0);
        drive(8'h00, 1'b1);
        drive(8'h10, 1'b0);

        // randomized traffic with occasional resets
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: r = 8'($urandom);
                1: r = 8'h01 << $urandom_range(0, 7);
                2: r = r & 8'($urandom);
                3: r = 8'h00;
                default: ;
            endcase
            rl = ($urandom_range(0, 3) == 0);
            drive(r, rl);
            if (i % 700 == 350) reset_pulse(1'b1);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_sched.md
MUX_RR_SCHED -- requirements
Module: mux_rr_sched

Interface
REQ-001 Parameter HOLD_MAX, default 4, max consecutive cycles one grant is held when timeout is compiled in (legal 1..15).
REQ-002 Parameter N, default 8, requester count; fixed at 8 in this revision (select width 3).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  8  per-requester request, level-sensitive; req[k] asks for mux input k.
REQ-006 rel  input  1  current grantee releases the mux; sampled only in GRANT.
REQ-007 gnt  output  8  one-hot grant, all-zero when idle.
REQ-008 s  output  3  select to the 8:1 mux; equals the index of the set gnt bit while granted.
REQ-009 gnt_vld  output  1  high exactly when gnt is non-zero.
REQ-010 to_evt  output  1  one-cycle pulse when a grant ends by timeout.

Function
REQ-011 States: IDLE, GRANT; all outputs registered.
REQ-012 Round-robin pointer ptr (3 bits) holds the last granted index; search order ptr+1, ptr+2, ... ptr, modulo 8.
REQ-013 IDLE with req != 0: winner = first set req in search order; next edge sets gnt, s, gnt_vld, ptr := winner, state := GRANT (latency 1 cycle from req to gnt).
REQ-014 IDLE with req == 0: stay IDLE, gnt = 0, gnt_vld = 0, s holds last value.
REQ-015 GRANT end condition: rel = 1, or req[s] = 0, or timeout (REQ-024).
REQ-016 GRANT, no end condition: hold gnt, s unchanged.
REQ-017 GRANT, end condition, other req bits set: regrant to next winner on the same edge (back-to-back, no idle bubble).
REQ-018 GRANT, end condition, only req[s] set (rel or timeout): regrant same index; hold counter restarts.
REQ-019 GRANT, end condition, req == 0: go IDLE, gnt = 0, gnt_vld = 0.
REQ-020 Requests arriving in the same cycle as rel are included in the regrant search.
REQ-021 gnt is never multi-hot; at most one bit set on any cycle.
REQ-022 Hold counter (4 bits) clears on every new grant, increments each GRANT cycle, saturates at HOLD_MAX-1.

Reset
REQ-023 rst_n low, at any time including mid-grant: state := IDLE, gnt := 0, gnt_vld := 0, s := 0, ptr := 7 (first search starts at index 0), counter := 0, to_evt := 0; first grant possible on the second rising edge after rst_n rises.

Configuration
REQ-024 Macro MUX_RR_SCHED_TIMEOUT_EN defined: GRANT is ended when the counter equals HOLD_MAX-1 without rel, and to_evt pulses on that edge.
REQ-025 MUX_RR_SCHED_TIMEOUT_EN undefined: no timeout, grant held until rel or req drop; to_evt tied 0; counter not implemented.

Structure
REQ-026 Package mux_sched_pkg holds the state enum (IDLE, GRANT), N = 8, SEL_W = 3.
REQ-027 Sub-module rr_pick: combinational rotate-priority finder (req, ptr -> winner index, found flag); instantiated once.

Verification
REQ-028 Reset, req = 8'h01 -> one cycle later gnt = 8'h01, s = 0, gnt_vld = 1.
REQ-029 req = 8'hFF held, rel pulsed each grant -> s sequence 0,1,2,...,7,0; one grant per rel, no gap cycles.
REQ-030 Granted s = 3, req = 8'h88, rel = 1 -> next edge gnt = 8'h80, s = 7; then rel with req = 8'h08 -> s = 3.
REQ-031 Timeout build, HOLD_MAX = 4, req = 8'h05, no rel -> s = 0 for 4 cycles, to_evt pulse, s = 2; without macro s stays 0 indefinitely.
REQ-032 rst_n low during GRANT with s = 5 -> gnt = 0, s = 0 immediately (asynchronous); after release, req = 8'h20 -> s = 5.
REQ-033 Granted s = 6, req[6] dropped, others 0 -> IDLE next edge, gnt = 0, s stays 6.
